// File: rtl/aurora_rx_lane.sv
// aurora_rx_lane: single-lane Aurora 64b/66b simplex receiver. It takes sync-header
// block lock with bitslip, descrambles the payload, decodes control blocks and
// reassembles frames onto an AXI-Stream master.
// Latency: a block sampled at edge N appears on m_axi_* after edge N+1, so it is seen at
// edge N+2. The status pulses (slip, soft_err, hard_err) and the levels (rx_aligned,
// rx_verified) are registered at edge N.
// Backpressure: none. The AXI master has no ready input, and input gaps are signalled by
// data_in_valid=0.
// Ports: clk/rst (async active-high); data_in_valid/data_in from the gearbox; slip to the
//   gearbox; rx_aligned/rx_verified/hard_err/soft_err status; m_axi_valid/last/data/keep.
module aurora_rx_lane #(
  parameter int LOCK_CNT   = 64,
  parameter int ERR_WIN    = 64,
  parameter int ERR_MAX    = 16,
  parameter int SLIP_WAIT  = 32,
  parameter int VERIFY_CNT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_in_valid,
  input  logic [65:0] data_in,
  output logic        slip,
  output logic        rx_aligned,
  output logic        rx_verified,
  output logic        hard_err,
  output logic        soft_err,
  output logic        m_axi_valid,
  output logic        m_axi_last,
  output logic [63:0] m_axi_data,
  output logic [7:0]  m_axi_keep
);

  localparam logic [15:0] LOCK_V = 16'(LOCK_CNT);
  localparam logic [15:0] WIN_L  = 16'(ERR_WIN - 1);
  localparam logic [15:0] ERR_V  = 16'(ERR_MAX);
  localparam logic [15:0] SLIP_L = 16'(SLIP_WAIT - 1);
  localparam logic [15:0] VER_V  = 16'(VERIFY_CNT);

  typedef enum logic [1:0] {HUNT, SLIP, LOCKED} state_t;
  state_t state, state_nx;

  logic [15:0] good_cnt, slip_cnt, hdr_cnt, bad_cnt, idle_cnt;
  logic [57:0] scr_state, scr_nx;
  logic [63:0] pay;

  // Self-synchronous descrambler. It unrolls over the 64 payload bits, LSB first.
  // The state takes in the scrambled (received) bit, so s[0] is the most recent bit.
  always_comb begin
    logic [57:0] s;
    logic        b;
    s   = scr_state;
    pay = '0;
    for (int i = 0; i < 64; i++) begin
      b      = data_in[i+2];
      pay[i] = b ^ s[57] ^ s[38];
      s      = {s[56:0], b};
    end
    scr_nx = s;
  end

  logic       hdr_ok, is_ctrl, is_data, locked_blk;
  logic       is_idle, is_sep, is_sep7, sep_bad;
  logic [2:0] sep_n;
  assign hdr_ok     = (data_in[1:0] == 2'b01) || (data_in[1:0] == 2'b10);
  assign is_data    = data_in[1:0] == 2'b01;
  assign is_ctrl    = data_in[1:0] == 2'b10;
  assign locked_blk = data_in_valid && (state == LOCKED);
  assign sep_n      = pay[10:8];
  assign is_idle    = is_ctrl && pay[7:0] == 8'h78;
  assign is_sep     = is_ctrl && pay[7:0] == 8'h1E;
  assign is_sep7    = is_ctrl && pay[7:0] == 8'hE1;
  assign sep_bad    = is_sep && sep_n > 3'd6;

  // Lock FSM next state. SLIP counts clock cycles and does not count blocks.
  logic slip_p, gain, lose;
  always_comb begin
    state_nx = state;
    slip_p   = 1'b0;
    gain     = 1'b0;
    lose     = 1'b0;
    case (state)
      HUNT: if (data_in_valid) begin
        if (!hdr_ok) begin
          state_nx = SLIP;
          slip_p   = 1'b1;
        end else if (good_cnt + 16'd1 == LOCK_V) begin
          state_nx = LOCKED;
          gain     = 1'b1;
        end
      end
      SLIP: if (slip_cnt == SLIP_L) state_nx = HUNT;
      LOCKED: if (data_in_valid && !hdr_ok && bad_cnt + 16'd1 == ERR_V) begin
        state_nx = HUNT;
        lose     = 1'b1;
      end
      default: state_nx = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_nx;
  end

  // Counters. Each one is held at zero outside the state that uses it, so every
  // state is entered with fresh counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_cnt  <= '0;
      slip_cnt  <= '0;
      hdr_cnt   <= '0;
      bad_cnt   <= '0;
      idle_cnt  <= '0;
      scr_state <= '0;
    end else begin
      if (data_in_valid) scr_state <= scr_nx;

      if (state != HUNT)            good_cnt <= '0;
      else if (data_in_valid)       good_cnt <= (!hdr_ok || gain) ? 16'd0 : good_cnt + 16'd1;

      slip_cnt <= (state == SLIP) ? slip_cnt + 16'd1 : 16'd0;

      if (state != LOCKED) begin
        hdr_cnt <= '0;
        bad_cnt <= '0;
      end else if (data_in_valid) begin
        if (hdr_cnt == WIN_L) begin
          hdr_cnt <= '0;
          bad_cnt <= '0;
        end else begin
          hdr_cnt <= hdr_cnt + 16'd1;
          bad_cnt <= bad_cnt + {15'd0, !hdr_ok};
        end
      end

      if (state != LOCKED)                idle_cnt <= '0;
      else if (data_in_valid && !rx_verified)
        idle_cnt <= (hdr_ok && is_idle) ? idle_cnt + 16'd1 : 16'd0;
    end
  end

  // Status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slip        <= 1'b0;
      hard_err    <= 1'b0;
      soft_err    <= 1'b0;
      rx_aligned  <= 1'b0;
      rx_verified <= 1'b0;
    end else begin
      slip     <= slip_p;
      hard_err <= lose;
      soft_err <= locked_blk &&
                  (!hdr_ok || (is_ctrl && !is_idle && !is_sep && !is_sep7) || sep_bad);
      if (gain)      rx_aligned <= 1'b1;
      else if (lose) rx_aligned <= 1'b0;
      if (lose)
        rx_verified <= 1'b0;
      else if (locked_blk && hdr_ok && is_idle && !rx_verified && idle_cnt + 16'd1 == VER_V)
        rx_verified <= 1'b1;
    end
  end

  // Beat decode, first pipeline stage.
  logic        beat_vld, beat_last;
  logic [63:0] beat_data, sep_mask;
  logic [7:0]  beat_keep, sep_keep;
  always_comb begin
    sep_keep = (8'd1 << sep_n) - 8'd1;
    sep_mask = '0;
    for (int k = 0; k < 8; k++) sep_mask[8*k +: 8] = {8{sep_keep[k]}};
    beat_vld  = 1'b0;
    beat_last = 1'b0;
    beat_data = '0;
    beat_keep = '0;
    if (locked_blk && is_data) begin
      beat_vld  = 1'b1;
      beat_data = pay;
      beat_keep = 8'hFF;
    end else if (locked_blk && is_sep && !sep_bad) begin
      beat_vld  = 1'b1;
      beat_last = 1'b1;
      beat_data = (pay >> 16) & sep_mask;
      beat_keep = sep_keep;
    end else if (locked_blk && is_sep7) begin
      beat_vld  = 1'b1;
      beat_last = 1'b1;
      beat_data = pay >> 8;
      beat_keep = 8'h7F;
    end
  end

  logic        s1_vld, s1_last;
  logic [63:0] s1_data;
  logic [7:0]  s1_keep;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld      <= 1'b0;
      s1_last     <= 1'b0;
      s1_data     <= '0;
      s1_keep     <= '0;
      m_axi_valid <= 1'b0;
      m_axi_last  <= 1'b0;
      m_axi_data  <= '0;
      m_axi_keep  <= '0;
    end else begin
      s1_vld      <= beat_vld;
      s1_last     <= beat_last;
      s1_data     <= beat_data;
      s1_keep     <= beat_keep;
      m_axi_valid <= s1_vld;
      m_axi_last  <= s1_last;
      m_axi_data  <= s1_data;
      m_axi_keep  <= s1_keep;
    end
  end

endmodule

// File: tb/tb_aurora_rx_lane.sv
// tb_aurora_rx_lane: randomized bench for aurora_rx_lane with a scoreboard. A block-level
// reference model (transmit scrambler, lock and window bookkeeping, frame decode) queues
// the expected beats and status events. A negedge monitor compares them with the DUT.
module tb_aurora_rx_lane;
  localparam int LOCK_CNT = 64, ERR_WIN = 64, ERR_MAX = 16, SLIP_WAIT = 32, VERIFY_CNT = 32;

  logic        clk = 1'b0, rst = 1'b1, data_in_valid = 1'b0;
  logic [65:0] data_in = '0;
  logic        slip, rx_aligned, rx_verified, hard_err, soft_err;
  logic        m_axi_valid, m_axi_last;
  logic [63:0] m_axi_data;
  logic [7:0]  m_axi_keep;

  aurora_rx_lane dut (
    .clk(clk), .rst(rst), .data_in_valid(data_in_valid), .data_in(data_in),
    .slip(slip), .rx_aligned(rx_aligned), .rx_verified(rx_verified),
    .hard_err(hard_err), .soft_err(soft_err), .m_axi_valid(m_axi_valid),
    .m_axi_last(m_axi_last), .m_axi_data(m_axi_data), .m_axi_keep(m_axi_keep)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0, miscompares = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40) $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference model state.
  typedef struct { int c; logic [63:0] d; logic [7:0] k; logic l; } beat_t;
  beat_t bq[$];
  bit p_slip[int], p_soft[int], p_hard[int], al_chg[int], ve_chg[int];
  bit exp_al = 0, exp_ve = 0;
  bit tx_hist[$];
  int mode = 0;  // 0 hunt, 1 slip wait, 2 locked
  int good = 0, slip_edge = 0, hdr_idx = 0, cur_win = 0, win_bad = 0, idle_n = 0;
  bit ver = 0;

  task automatic scramble(input logic [63:0] d, output logic [63:0] s);
    bit a58, a39;
    for (int i = 0; i < 64; i++) begin
      a58 = (tx_hist.size() >= 58) ? tx_hist[tx_hist.size()-58] : 1'b0;
      a39 = (tx_hist.size() >= 39) ? tx_hist[tx_hist.size()-39] : 1'b0;
      s[i] = d[i] ^ a58 ^ a39;
      tx_hist.push_back(s[i]);
      if (tx_hist.size() > 58) void'(tx_hist.pop_front());
    end
  endtask

  task automatic push_beat(input int c, input logic [63:0] d, input logic [7:0] k, input logic l);
    beat_t b;
    b.c = c; b.d = d; b.k = k; b.l = l;
    bq.push_back(b);
  endtask

  // Send one block on the next edge and update the model with its expected effects.
  // Effects registered at that edge appear at cyc e; a beat appears at cyc e+1.
  task automatic send(input logic [1:0] h, input logic [63:0] p);
    int e, n;
    bit ok;
    logic [63:0] sp, d;
    logic [7:0] k;
    e = cyc + 1;
    scramble(p, sp);
    data_in = {sp, h};
    data_in_valid = 1'b1;
    ok = (h == 2'b01) || (h == 2'b10);
    if (mode == 1 && e > slip_edge + SLIP_WAIT) begin mode = 0; good = 0; end
    if (mode == 0) begin
      if (!ok) begin
        good = 0; mode = 1; slip_edge = e; p_slip[e] = 1;
      end else begin
        good++;
        if (good == LOCK_CNT) begin
          mode = 2; good = 0; al_chg[e] = 1;
          hdr_idx = 0; cur_win = 0; win_bad = 0; idle_n = 0;
        end
      end
    end else if (mode == 2) begin
      if (hdr_idx / ERR_WIN != cur_win) begin cur_win = hdr_idx / ERR_WIN; win_bad = 0; end
      hdr_idx++;
      if (!ok) begin
        p_soft[e] = 1;
        win_bad++;
        if (!ver) idle_n = 0;
        if (win_bad == ERR_MAX) begin
          p_hard[e] = 1; al_chg[e] = 0; ve_chg[e] = 0; ver = 0; mode = 0; good = 0;
        end
      end else if (h == 2'b01) begin
        if (!ver) idle_n = 0;
        push_beat(e + 1, p, 8'hFF, 1'b0);
      end else if (p[7:0] == 8'h78) begin
        if (!ver) begin
          idle_n++;
          if (idle_n == VERIFY_CNT) begin ver = 1; ve_chg[e] = 1; end
        end
      end else begin
        if (!ver) idle_n = 0;
        d = '0; k = '0;
        if (p[7:0] == 8'h1E) begin
          n = int'(p[10:8]);
          if (n > 6) p_soft[e] = 1;
          else begin
            for (int j = 0; j < n; j++) begin d[8*j +: 8] = p[8*(j+2) +: 8]; k[j] = 1'b1; end
            push_beat(e + 1, d, k, 1'b1);
          end
        end else if (p[7:0] == 8'hE1) begin
          for (int j = 0; j < 7; j++) begin d[8*j +: 8] = p[8*(j+1) +: 8]; k[j] = 1'b1; end
          push_beat(e + 1, d, k, 1'b1);
        end else p_soft[e] = 1;
      end
    end
    @(negedge clk);
    data_in_valid = 1'b0;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic send_idle();
    logic [63:0] p;
    p = rnd64(); p[7:0] = 8'h78;
    send(2'b10, p);
  endtask

  task automatic send_sep(input logic [2:0] n, input logic [47:0] bytes);
    logic [63:0] p;
    p = rnd64(); p[7:0] = 8'h1E; p[10:8] = n; p[63:16] = bytes;
    send(2'b10, p);
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    bq.delete(); p_slip.delete(); p_soft.delete(); p_hard.delete();
    al_chg.delete(); ve_chg.delete(); tx_hist.delete();
    exp_al = 0; exp_ve = 0; mode = 0; good = 0; ver = 0; idle_n = 0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_slip"}, slip, 0);           chk({nm, "_aligned"}, rx_aligned, 0);
    chk({nm, "_verified"}, rx_verified, 0); chk({nm, "_hard"}, hard_err, 0);
    chk({nm, "_soft"}, soft_err, 0);       chk({nm, "_valid"}, m_axi_valid, 0);
    chk({nm, "_last"}, m_axi_last, 0);     chk({nm, "_data"}, m_axi_data, 0);
    chk({nm, "_keep"}, m_axi_keep, 0);
  endtask

  // Monitor: per-cycle status levels/pulses and the beat scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (al_chg.exists(cyc)) exp_al = al_chg[cyc];
      if (ve_chg.exists(cyc)) exp_ve = ve_chg[cyc];
      chk("rx_aligned", rx_aligned, exp_al);
      chk("rx_verified", rx_verified, exp_ve);
      chk("slip", slip, p_slip.exists(cyc));
      chk("soft_err", soft_err, p_soft.exists(cyc));
      chk("hard_err", hard_err, p_hard.exists(cyc));
      while (bq.size() > 0 && bq[0].c < cyc) begin
        chk("beat_missing_cyc", 64'(cyc), 64'(bq[0].c));
        void'(bq.pop_front());
      end
      if (m_axi_valid) begin
        if (bq.size() == 0 || bq[0].c != cyc) begin
          chk("beat_unexpected", 1, 0);
        end else begin
          chk("beat_data", m_axi_data, bq[0].d);
          chk("beat_keep", m_axi_keep, bq[0].k);
          chk("beat_last", m_axi_last, bq[0].l);
          void'(bq.pop_front());
        end
      end else if (bq.size() > 0 && bq[0].c == cyc) begin
        chk("beat_missing", 0, 1);
        void'(bq.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end in time");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] p;
    int r, bw;
    bit bad;
    gap(3);
    chk_all_zero("reset");
    rst = 1'b0;
    gap(2);

    // Lock and verify on idles.
    for (int i = 0; i < 64; i++) send_idle();
    chk("aligned_after_64", rx_aligned, 1);
    for (int i = 0; i < 31; i++) send_idle();
    chk("not_verified_31", rx_verified, 0);
    send_idle();
    chk("verified_after_32", rx_verified, 1);

    // Directed frame: 3 data blocks + separator n=3 (AA BB CC).
    send(2'b01, 64'h0706050403020100);
    send(2'b01, 64'h0F0E0D0C0B0A0908);
    send(2'b01, 64'h1716151413121110);
    send_sep(3'd3, {24'h0, 24'hCCBBAA});
    send_sep(3'd0, 48'h0);
    send(2'b10, 64'h77665544332211E1);
    p = rnd64(); p[7:0] = 8'h55;
    send(2'b10, p);
    gap(3);

    // Random frames with input gaps and error blocks.
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      p = rnd64();
      if (r < 5) send(2'b01, p);
      else if (r == 5) send_sep(3'($urandom_range(0, 7)), p[47:0]);
      else if (r == 6) begin p[7:0] = 8'hE1; send(2'b10, p); end
      else if (r == 7) begin p[7:0] = ($urandom_range(0, 1) != 0) ? 8'h55 : 8'h00; send(2'b10, p); end
      else send_idle();
      if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 3));
    end

    // Up to 15 invalid headers per window: lock must hold.
    for (int i = 0; i < 3 * ERR_WIN; i++) begin
      bw = (hdr_idx / ERR_WIN == cur_win) ? win_bad : 0;
      bad = (bw < ERR_MAX - 1) && ($urandom_range(0, 2) == 0);
      if (bad) send(($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00, rnd64());
      else send(2'b01, rnd64());
    end
    chk("lock_held_15", rx_aligned, 1);

    // Drive invalid headers until the model drops lock at the 16th in a window.
    for (int i = 0; i < 200 && mode == 2; i++) begin
      if ($urandom_range(0, 1) != 0) send(2'b11, rnd64());
      else send(2'b01, rnd64());
    end
    gap(3);
    chk("lost_aligned", rx_aligned, 0);
    chk("lost_verified", rx_verified, 0);

    // Bad header at the 10th block in HUNT, then the slip wait and a fresh lock.
    for (int i = 0; i < 9; i++) send_idle();
    send(2'b11, rnd64());
    for (int i = 0; i < SLIP_WAIT + LOCK_CNT - 1; i++) begin
      if (i == 4) send(2'b00, rnd64());
      else send_idle();
    end
    chk("no_lock_63_fresh", rx_aligned, 0);
    send_idle();
    chk("lock_64_fresh", rx_aligned, 1);
    for (int i = 0; i < VERIFY_CNT; i++) send_idle();
    chk("reverified", rx_verified, 1);

    // Reset mid-frame with one beat on the output and one in flight.
    send(2'b01, rnd64());
    send(2'b01, rnd64());
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    model_reset();
    gap(3);
    rst = 1'b0;
    gap(6);

    // Relock after reset and send a closing frame.
    for (int i = 0; i < LOCK_CNT; i++) send_idle();
    send(2'b01, rnd64());
    send(2'b10, 64'h77665544332211E1);
    gap(6);
    chk("scoreboard_empty", 64'(bq.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
